// File: rtl/hv_timing_gen.sv
// Raster timing generator: H/V counters, blanking, offset-adjustable sync,
// frame strobe and blanked RGB, all advancing on the pixel clock enable.
module hv_timing_gen #(
  parameter int unsigned HW        = 9,
  parameter int unsigned VW        = 9,
  parameter int unsigned CW        = 12,
  parameter int unsigned H_TOTAL   = 394,
  parameter int unsigned HB_START  = 297,
  parameter int unsigned HS_START  = 297,
  parameter int unsigned HS_END    = 321,
  parameter int unsigned V_TOTAL   = 263,
  parameter int unsigned VB_START  = 223,
  parameter int unsigned VS_START  = 226,
  parameter int unsigned VS_END    = 233,
  parameter int unsigned MASK_LEFT = 2,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic          PCLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic [3:0]    HOFS,
  input  logic [3:0]    VOFS,
  input  logic [CW-1:0] iRGB,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic [CW-1:0] oRGB,
  output logic          HBLK,
  output logic          VBLK,
  output logic          HSYN,
  output logic          VSYN,
  output logic          FRAME
);

  localparam int unsigned HXW = HW + 1;
  localparam int unsigned VXW = VW + 1;

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic           hblk_q, hblk_d;
  logic           vblk_q, vblk_d;
  logic           hsyn_q, hsyn_d;
  logic           vsyn_q, vsyn_d;
  logic           frame_q, frame_d;
  logic [CW-1:0]  rgb_q, rgb_d;
  logic [3:0]     hofs_q, hofs_d;
  logic [3:0]     vofs_q, vofs_d;

  logic [HXW-1:0] hs_s, hs_e;
  logic [VXW-1:0] vs_s, vs_e;
  logic           h_last, v_last, frame_wrap;

  // Effective sync positions from the offsets latched at the last frame wrap
  always_comb begin
    hs_s = HXW'(HS_START) + {{(HXW-4){hofs_q[3]}}, hofs_q};
    hs_e = HXW'(HS_END)   + {{(HXW-4){hofs_q[3]}}, hofs_q};
    vs_s = VXW'(VS_START) + {{(VXW-4){vofs_q[3]}}, vofs_q};
    vs_e = VXW'(VS_END)   + {{(VXW-4){vofs_q[3]}}, vofs_q};
    h_last     = (hcnt_q == HW'(H_TOTAL - 1));
    v_last     = (vcnt_q == VW'(V_TOTAL - 1));
    frame_wrap = h_last & v_last;
  end

  always_comb begin
    hcnt_d  = hcnt_q + HW'(1);
    vcnt_d  = vcnt_q;
    hblk_d  = hblk_q;
    vblk_d  = vblk_q;
    hsyn_d  = hsyn_q;
    vsyn_d  = vsyn_q;
    frame_d = frame_wrap;
    hofs_d  = frame_wrap ? HOFS : hofs_q;
    vofs_d  = frame_wrap ? VOFS : vofs_q;

    if (hcnt_q == HW'(HB_START))  hblk_d = 1'b1;
    if ({1'b0, hcnt_q} == hs_s)   hsyn_d = SYNC_POL;
    if ({1'b0, hcnt_q} == hs_e)   hsyn_d = ~SYNC_POL;

    if (h_last) begin
      hcnt_d = '0;
      hblk_d = 1'b0;
      hsyn_d = ~SYNC_POL;
      // Line step: same trigger ordering as horizontal, deassert wins on overlap
      vcnt_d = vcnt_q + VW'(1);
      if (vcnt_q == VW'(VB_START)) vblk_d = 1'b1;
      if ({1'b0, vcnt_q} == vs_s)  vsyn_d = SYNC_POL;
      if ({1'b0, vcnt_q} == vs_e)  vsyn_d = ~SYNC_POL;
      if (v_last) begin
        vcnt_d = '0;
        vblk_d = 1'b0;
        vsyn_d = ~SYNC_POL;
      end
    end

    // Blanking uses pre-edge state, giving the one-pixel skew of the original
    if (hblk_q || vblk_q || (hcnt_q < HW'(MASK_LEFT))) rgb_d = '0;
    else                                               rgb_d = iRGB;
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= ~SYNC_POL;
      vsyn_q  <= ~SYNC_POL;
      frame_q <= 1'b0;
      rgb_q   <= '0;
      hofs_q  <= '0;
      vofs_q  <= '0;
    end else if (CE) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      hsyn_q  <= hsyn_d;
      vsyn_q  <= vsyn_d;
      frame_q <= frame_d;
      rgb_q   <= rgb_d;
      hofs_q  <= hofs_d;
      vofs_q  <= vofs_d;
    end
  end

  assign HPOS  = hcnt_q;
  assign VPOS  = vcnt_q;
  assign oRGB  = rgb_q;
  assign HBLK  = hblk_q;
  assign VBLK  = vblk_q;
  assign HSYN  = hsyn_q;
  assign VSYN  = vsyn_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Scoreboard bench for hv_timing_gen on a shrunken raster (40x20, 800 px/frame).
module tb_hv_timing_gen;

  localparam int unsigned HW = 9;
  localparam int unsigned VW = 9;
  localparam int unsigned CW = 12;

  localparam int S_HPOS = 0, S_VPOS = 1, S_HBLK = 2, S_VBLK = 3;
  localparam int S_HSYN = 4, S_VSYN = 5, S_FRAME = 6, S_RGB = 7;

  logic          PCLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CE = 1'b1;
  logic [3:0]    HOFS = 4'd0;
  logic [3:0]    VOFS = 4'd0;
  logic [CW-1:0] iRGB = '0;
  logic [HW-1:0] HPOS;
  logic [VW-1:0] VPOS;
  logic [CW-1:0] oRGB;
  logic          HBLK, VBLK, HSYN, VSYN, FRAME;

  hv_timing_gen #(
    .HW(HW), .VW(VW), .CW(CW),
    .H_TOTAL(40), .HB_START(30), .HS_START(32), .HS_END(36),
    .V_TOTAL(20), .VB_START(15), .VS_START(8), .VS_END(10),
    .MASK_LEFT(2), .SYNC_POL(1'b0)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .CE(CE), .HOFS(HOFS), .VOFS(VOFS),
    .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
    .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN), .FRAME(FRAME)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int unsigned pc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  exp_t        keep_q[$];
  int unsigned pc = 0;
  int unsigned max_pc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] act;

  // PCLK edges since the last reset release
  always @(posedge PCLK or posedge RESET) begin
    if (RESET) pc <= 0;
    else       pc <= pc + 1;
  end

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_HPOS:  return 32'(HPOS);
      S_VPOS:  return 32'(VPOS);
      S_HBLK:  return 32'(HBLK);
      S_VBLK:  return 32'(VBLK);
      S_HSYN:  return 32'(HSYN);
      S_VSYN:  return 32'(VSYN);
      S_FRAME: return 32'(FRAME);
      default: return 32'(oRGB);
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      S_HPOS:  return "HPOS";
      S_VPOS:  return "VPOS";
      S_HBLK:  return "HBLK";
      S_VBLK:  return "VBLK";
      S_HSYN:  return "HSYN";
      S_VSYN:  return "VSYN";
      S_FRAME: return "FRAME";
      default: return "oRGB";
    endcase
  endfunction

  // Monitor: each output sample is matched against queued expectations for this edge
  always @(negedge PCLK) begin
    keep_q.delete();
    foreach (sbq[i]) begin
      if (sbq[i].pc == pc) begin
        total++;
        act = actual(sbq[i].sel);
        if (act !== sbq[i].val) begin
          bad++;
          $display("FAIL %s pc=%0d actual=%0h required=%0h",
                   sname(sbq[i].sel), pc, act, sbq[i].val);
        end
      end else if (sbq[i].pc < pc) begin
        total++;
        bad++;
        $display("FAIL %s pc=%0d never sampled (now pc=%0d) required=%0h",
                 sname(sbq[i].sel), sbq[i].pc, pc, sbq[i].val);
      end else begin
        keep_q.push_back(sbq[i]);
      end
    end
    sbq = keep_q;
  end

  task automatic ex(input int unsigned p, input int s, input logic [31:0] v);
    exp_t e;
    e.pc = p; e.sel = s; e.val = v;
    sbq.push_back(e);
    if (p > max_pc) max_pc = p;
  endtask

  task automatic ex_reset_vals();
    ex(0, S_HPOS, 0); ex(0, S_VPOS, 0); ex(0, S_HBLK, 1); ex(0, S_VBLK, 1);
    ex(0, S_HSYN, 1); ex(0, S_VSYN, 1); ex(0, S_FRAME, 0); ex(0, S_RGB, 0);
  endtask

  task automatic run_to(input int unsigned k);
    while (pc < k) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic finish_phase();
    run_to(max_pc + 1);
    @(negedge PCLK);
    #1;
    max_pc = 0;
  endtask

  task automatic do_reset();
    @(posedge PCLK);
    #1;
    RESET = 1'b1;
    CE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    // Power-on reset values
    ex_reset_vals();
    @(negedge PCLK);
    #1;

    // Free run, offsets 0, constant white pixel input
    iRGB = 12'hFFF;
    do_reset();
    ex(1, S_HPOS, 1); ex(1, S_VPOS, 0); ex(1, S_HBLK, 1); ex(1, S_VBLK, 1);
    ex(32, S_HSYN, 1); ex(33, S_HSYN, 0); ex(36, S_HSYN, 0); ex(37, S_HSYN, 1);
    ex(39, S_HPOS, 39); ex(40, S_HPOS, 0); ex(40, S_VPOS, 1); ex(40, S_HBLK, 0);
    ex(70, S_HBLK, 0); ex(71, S_HBLK, 1);
    ex(359, S_VSYN, 1); ex(360, S_VSYN, 0); ex(439, S_VSYN, 0); ex(440, S_VSYN, 1);
    ex(400, S_VBLK, 1); ex(500, S_RGB, 0);
    ex(799, S_HPOS, 39); ex(799, S_VPOS, 19); ex(799, S_VBLK, 1); ex(799, S_FRAME, 0);
    ex(800, S_HPOS, 0); ex(800, S_VPOS, 0); ex(800, S_VBLK, 0); ex(800, S_FRAME, 1);
    ex(801, S_FRAME, 0);
    ex(802, S_RGB, 0); ex(803, S_RGB, 12'hFFF); ex(831, S_RGB, 12'hFFF); ex(832, S_RGB, 0);
    ex(842, S_RGB, 0); ex(843, S_RGB, 12'hFFF);
    ex(1009, S_RGB, 12'hFFF); ex(1010, S_RGB, 12'h5A3); ex(1011, S_RGB, 12'h5A3);
    ex(1012, S_RGB, 12'hFFF);
    ex(1431, S_RGB, 12'hFFF); ex(1439, S_VBLK, 0); ex(1440, S_VBLK, 1); ex(1450, S_RGB, 0);
    ex(1599, S_FRAME, 0); ex(1600, S_FRAME, 1);
    run_to(1009);
    iRGB = 12'h5A3;
    run_to(1011);
    iRGB = 12'hFFF;
    finish_phase();

    // Alternating clock enable: two PCLK edges per pixel
    do_reset();
    ex(1, S_HPOS, 1); ex(2, S_HPOS, 1);
    ex(64, S_HSYN, 1); ex(65, S_HSYN, 0); ex(66, S_HSYN, 0); ex(72, S_HSYN, 0);
    ex(73, S_HSYN, 1); ex(74, S_HSYN, 1);
    ex(77, S_HPOS, 39); ex(78, S_HPOS, 39); ex(78, S_VPOS, 0);
    ex(79, S_HPOS, 0); ex(79, S_VPOS, 1); ex(79, S_HBLK, 0); ex(80, S_HPOS, 0);
    ex(158, S_HPOS, 39); ex(159, S_HPOS, 0); ex(159, S_VPOS, 2);
    for (int k = 1; k <= 170; k++) begin
      CE = ((k % 2) == 1);
      @(posedge PCLK);
      #1;
    end
    CE = 1'b1;
    finish_phase();

    // Offsets take effect only at the following frame wrap
    do_reset();
    ex(512, S_HSYN, 1); ex(513, S_HSYN, 0); ex(517, S_HSYN, 1);
    ex(874, S_HSYN, 1); ex(875, S_HSYN, 0); ex(878, S_HSYN, 0); ex(879, S_HSYN, 1);
    ex(870, S_HBLK, 0); ex(871, S_HBLK, 1);
    ex(1160, S_VSYN, 1); ex(1400, S_VSYN, 1); ex(1440, S_VSYN, 0); ex(1440, S_VBLK, 1);
    ex(1439, S_VBLK, 0); ex(1480, S_VSYN, 0); ex(1520, S_VSYN, 1);
    ex(1624, S_HSYN, 1); ex(1625, S_HSYN, 0); ex(1628, S_HSYN, 0); ex(1629, S_HSYN, 1);
    ex(1639, S_VSYN, 1); ex(1640, S_VSYN, 0); ex(1719, S_VSYN, 0); ex(1720, S_VSYN, 1);
    ex(1670, S_HBLK, 0); ex(1671, S_HBLK, 1);
    ex(2430, S_HBLK, 0); ex(2430, S_HSYN, 1); ex(2431, S_HBLK, 1); ex(2431, S_HSYN, 0);
    ex(2434, S_HSYN, 0); ex(2435, S_HSYN, 1);
    run_to(400);
    HOFS = 4'd2;
    VOFS = 4'd7;
    run_to(1000);
    HOFS = 4'h8;
    VOFS = 4'h8;
    run_to(1700);
    HOFS = 4'hE;
    VOFS = 4'd0;
    finish_phase();

    // Asynchronous reset in the middle of a frame
    HOFS = 4'd2;
    VOFS = 4'd0;
    do_reset();
    ex(873, S_HSYN, 1); ex(875, S_HSYN, 0);
    ex(1020, S_HPOS, 20); ex(1020, S_VPOS, 5); ex(1020, S_HBLK, 0); ex(1020, S_VBLK, 0);
    finish_phase();
    @(posedge PCLK);
    #3;
    RESET = 1'b1;
    ex_reset_vals();
    @(negedge PCLK);
    #1;
    @(posedge PCLK);
    #1;
    RESET = 1'b0;
    ex(1, S_HPOS, 1); ex(20, S_HBLK, 1); ex(33, S_HSYN, 0); ex(34, S_HSYN, 0);
    ex(37, S_HSYN, 1); ex(39, S_HBLK, 1);
    ex(40, S_HPOS, 0); ex(40, S_VPOS, 1); ex(40, S_HBLK, 0); ex(40, S_VBLK, 1);
    finish_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
